lcg_stim_gen: RTL
=================

// Module: lcg_stim_gen
// PURPOSE
//  Synthesizable, parametrised LCG stimulus source for fuzz-rewiring harnesses.
//  Emits OUT_W-bit pseudo-random vectors over a valid/ready handshake. Each
//  vector is assembled from 32-bit LCG words, one LCG step per clock. A run is
//  seeded and bounded by a vector count. It sits between the harness controller
//  and the DUT input bus, replacing the behavioural per-negedge stimulus loop.
// PARAMETERS
//  OUT_W        137          vector width; NW = ceil(OUT_W/32) LCG words/vector
//  CNT_W        32           width of vector-count request and counter
//  LCG_MUL      32'h41C64E6D LCG multiplier
//  LCG_INC      32'h3039     LCG increment
//  SEED_DEF     240029841    seed used when start arrives with seed_load=0
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      begin a run; sampled only in IDLE or DONE
//  seed_load  in   1      with start: 1 = use seed_in, 0 = use SEED_DEF
//  seed_in    in   32     run seed
//  n_vec      in   CNT_W  vectors to emit in this run, latched on start
//  abort      in   1      synchronous return to IDLE
//  stim_data  out  OUT_W  current vector
//  stim_valid out  1      stim_data valid
//  stim_ready in   1      consumer accepts on valid&ready
//  busy       out  1      state is GEN or HOLD
//  done       out  1      high in DONE
//  vec_cnt    out  CNT_W  vectors accepted in this run
//  sig_out    out  32     run signature (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, LCG=0, stim_data=0, vec_cnt=0, sig_out=0.
//   stim_valid, busy and done are all 0.
//  LCG step: s <= s*LCG_MUL + LCG_INC, mod 2^32; the new s is the word produced.
//  Packing: word k fills bits [32k+31:32k]. Last word fills only its low
//   OUT_W-32*(NW-1) bits, and its upper bits are discarded (they still consume a step).
//  FSM:
//   IDLE: start -> s=seed, latch n_vec, vec_cnt=0, k=0. Go to DONE if n_vec==0, else GEN.
//   GEN:  one step per clock, write word k, k++. After word NW-1, go to HOLD.
//   HOLD: stim_valid=1, stim_data stable. On stim_ready: vec_cnt++.
//    If vec_cnt+1==n_vec go to DONE, else go to GEN with k=0.
//   DONE: done=1, stim_data holds the last vector. start re-seeds exactly as in IDLE.
//  Latency: start sampled at edge E -> stim_valid visible after edge E+NW.
//   After each accept, the next vector is valid NW+1 edges later.
//   Throughput is 1 vector per NW+1 clocks with ready held high.
//  start in GEN/HOLD is ignored, and latched n_vec/seed stay unchanged.
//  abort, from any state, returns to IDLE at the next edge with stim_valid=0.
//   LCG, vec_cnt and sig_out are held, not cleared. abort has priority over start
//   and stim_ready in the same cycle.
//  Reset mid-run: identical to power-on reset; no partial vector survives.
//  vec_cnt does not wrap: n_vec is at most 2^CNT_W-1, so the run ends first.
// CONFIGURATION
//  LCG_STIM_SIG_EN defined: on every accept, sig_out <= rotl(sig_out,1) ^ xor of
//   all 32-bit words of stim_data, with the last word zero-padded. sig_out is
//   cleared on start.
//  LCG_STIM_SIG_EN undefined: sig_out is tied to 32'h0 and no signature logic is built.
// TESTING
//  1. OUT_W=64, seed_load=1, seed_in=0, n_vec=1, ready=1 ->
//     stim_data=64'hD3DC167E_00003039, valid 2 edges after start, then done=1.
//  2. Default params, seed_load=0, n_vec=3, ready=1 -> 3 accepts, each 6 clocks
//     apart. The 5-word sequence matches a software LCG from 240029841.
//     vec_cnt=3 and done=1.
//  3. ready held 0 for 10 clocks in HOLD -> stim_valid stays 1, stim_data and
//     LCG state are frozen, and vec_cnt is unchanged.
//  4. n_vec=0 with start -> DONE on the next edge with stim_valid never asserted.
//     start in GEN is ignored.
//  5. abort asserted in the same cycle as stim_ready in HOLD -> IDLE, valid=0,
//     vec_cnt not incremented. rst_n=0 mid-GEN -> all outputs at reset values.
//  6. LCG_STIM_SIG_EN, OUT_W=64, seed 0, n_vec=1 -> sig_out=32'hD3DC2647.
//     Without the macro, sig_out=0.

Source files
------------

// File: rtl/lcg_stim_gen_if.sv
// Stimulus bus between the LCG generator (master) and the consumer (slave).
// Handshake: stim_data is valid while stim_valid=1 and is held stable until accepted.
// A transfer completes on a rising edge where stim_valid & stim_ready are both 1.
// stim_ready may be asserted at any time and does not depend on stim_valid.
interface lcg_stim_gen_if #(
  parameter int OUT_W = 137
);
  logic [OUT_W-1:0] stim_data;
  logic             stim_valid;
  logic             stim_ready;

  modport master (output stim_data, output stim_valid, input stim_ready);
  modport slave  (input stim_data, input stim_valid, output stim_ready);
endinterface

// File: rtl/lcg_stim_gen.sv
// Seeded LCG stimulus source: assembles OUT_W-bit vectors from 32-bit LCG words.
// Optional run signature is enabled with `define LCG_STIM_SIG_EN.
module lcg_stim_gen #(
  parameter int          OUT_W    = 137,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] LCG_MUL  = 32'h41C64E6D,
  parameter logic [31:0] LCG_INC  = 32'h3039,
  parameter logic [31:0] SEED_DEF = 32'd240029841
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic [CNT_W-1:0] n_vec,
  input  logic             abort,
  lcg_stim_gen_if.master   stim,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [31:0]      sig_out,
  output logic [1:0]       dbg_state
);

  localparam int NW = (OUT_W + 31) / 32;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q;
  logic [31:0]      lcg_q;
  logic [OUT_W-1:0] data_q;
  logic [KW-1:0]    k_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0]      lcg_step;
  logic [OUT_W-1:0] data_ins;
  logic             last_vec;

  assign lcg_step = lcg_q * LCG_MUL + LCG_INC;
  assign last_vec = (CNT_W'(cnt_q + 1'b1) == n_q);

  // Drop the freshly stepped word into slot k_q; bits past OUT_W simply have no home.
  always_comb begin
    data_ins = data_q;
    for (int b = 0; b < OUT_W; b++) begin
      if ((b >> 5) == int'(k_q)) data_ins[b] = lcg_step[b[4:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lcg_q   <= '0;
      data_q  <= '0;
      k_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      // LCG, data, count and signature are deliberately kept for inspection.
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            lcg_q <= seed_load ? seed_in : SEED_DEF;
            n_q   <= n_vec;
            cnt_q <= '0;
            k_q   <= '0;
            if (n_vec == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= GEN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        GEN: begin
          lcg_q  <= lcg_step;
          data_q <= data_ins;
          if (k_q == KW'(NW - 1)) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        HOLD: begin
          if (stim.stim_ready) begin
            cnt_q   <= cnt_q + 1'b1;
            valid_q <= 1'b0;
            k_q     <= '0;
            if (last_vec) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= GEN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LCG_STIM_SIG_EN
  logic [31:0] sig_q;
  logic [31:0] fold;

  // XOR of all 32-bit words of the current vector, last word zero-padded.
  always_comb begin
    fold = '0;
    for (int b = 0; b < OUT_W; b++) begin
      fold[b[4:0]] = fold[b[4:0]] ^ data_q[b];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (!abort) begin
      if ((state_q == IDLE || state_q == DONE) && start) begin
        sig_q <= '0;
      end else if (state_q == HOLD && stim.stim_ready) begin
        sig_q <= {sig_q[30:0], sig_q[31]} ^ fold;
      end
    end
  end

  assign sig_out = sig_q;
`else
  assign sig_out = 32'h0;
`endif

  assign stim.stim_data  = data_q;
  assign stim.stim_valid = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign vec_cnt         = cnt_q;
  assign dbg_state       = state_q;

endmodule
